// File: rtl/lidar_pkg.sv
// rtl/lidar_pkg.sv - shared state encoding and limits for the inertia accumulator controller
package lidar_pkg;

    localparam int ADD_LAT_MAX = 7;
    localparam int DRAIN_W     = 3;
    localparam int TMO_DEFAULT = 1024;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACC   = 2'd1,
        S_DRAIN = 2'd2,
        S_HOLD  = 2'd3
    } acc_state_e;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous load (load wins over increment)
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/inertia_acc_ctrl.sv
// rtl/inertia_acc_ctrl.sv - point-cluster sequencer for the xx/yy/xy tensor accumulators
// Optional watchdog: define INERTIA_ACC_CTRL_TIMEOUT_EN (adds parameter TMO).
module inertia_acc_ctrl
    import lidar_pkg::*;
#(
    parameter int ADD_LAT = 3,
    parameter int CNT_W   = 16
`ifdef INERTIA_ACC_CTRL_TIMEOUT_EN
    , parameter int TMO   = TMO_DEFAULT
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pt_valid,
    input  logic             pt_last,
    output logic             pt_ready,
    output logic             acc_ce,
    output logic             acc_clr,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [CNT_W-1:0] res_cnt,
    output logic             err
);

    localparam int LAT = (ADD_LAT > ADD_LAT_MAX) ? ADD_LAT_MAX : ADD_LAT;
    localparam logic [DRAIN_W-1:0] DRAIN_LOAD = (LAT > 0) ? DRAIN_W'(LAT - 1) : '0;
    localparam acc_state_e LAST_NEXT = (LAT == 0) ? S_HOLD : S_DRAIN;

    acc_state_e         state_q, state_d;
    logic [DRAIN_W-1:0] drain_q, drain_d;
    logic               accept;
    logic               timeout;

    // pt_ready is gated by rst so nothing is accepted while reset is held
    assign pt_ready  = rst && ((state_q == S_IDLE) || (state_q == S_ACC));
    assign accept    = pt_valid && pt_ready;
    assign res_valid = (state_q == S_HOLD);

    sat_counter #(.W(CNT_W)) u_pt_cnt (
        .clk_i      (clk),
        .rst_ni     (rst),
        .load_i     (accept && (state_q == S_IDLE)),
        .load_val_i (CNT_W'(1)),
        .inc_i      (accept && (state_q == S_ACC)),
        .cnt_o      (res_cnt)
    );

`ifdef INERTIA_ACC_CTRL_TIMEOUT_EN
    localparam int WD_W = (TMO > 1) ? $clog2(TMO) : 1;
    logic [WD_W-1:0] wd_cnt;

    // counts idle ACC cycles; the TMO-th consecutive idle cycle aborts the cluster
    sat_counter #(.W(WD_W)) u_wdog (
        .clk_i      (clk),
        .rst_ni     (rst),
        .load_i     (accept || (state_q != S_ACC)),
        .load_val_i ('0),
        .inc_i      (1'b1),
        .cnt_o      (wd_cnt)
    );

    assign timeout = (state_q == S_ACC) && !accept && (wd_cnt == WD_W'(TMO - 1));
`else
    assign timeout = 1'b0;
`endif

    assign err = timeout;

    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        acc_ce  = 1'b0;
        acc_clr = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                acc_ce = accept;
                if (accept) begin
                    acc_clr = 1'b1;
                    drain_d = DRAIN_LOAD;
                    state_d = pt_last ? LAST_NEXT : S_ACC;
                end
            end
            S_ACC: begin
                acc_ce = accept;
                if (accept && pt_last) begin
                    drain_d = DRAIN_LOAD;
                    state_d = LAST_NEXT;
                end else if (timeout) begin
                    acc_clr = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_DRAIN: begin
                acc_ce = 1'b1;
                if (drain_q == '0) begin
                    state_d = S_HOLD;
                end else begin
                    drain_d = drain_q - 1'b1;
                end
            end
            S_HOLD: begin
                if (res_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
        end
    end

endmodule

// File: tb/tb_inertia_acc_ctrl.sv
// tb/tb_inertia_acc_ctrl.sv - scoreboard bench: default instance plus ADD_LAT=0/CNT_W=4 instance
module tb_inertia_acc_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        pt_valid = 1'b0;
    logic        pt_last = 1'b0;
    logic        res_ready = 1'b0;

    logic        pt_ready, acc_ce, acc_clr, res_valid, err;
    logic [15:0] res_cnt;
    logic        pt_ready4, acc_ce4, acc_clr4, res_valid4, err4;
    logic [3:0]  res_cnt4;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int cnt;
        int cnt4;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

`ifdef INERTIA_ACC_CTRL_TIMEOUT_EN
    inertia_acc_ctrl #(.ADD_LAT(3), .CNT_W(16), .TMO(8)) dut (
        .clk(clk), .rst(rst), .pt_valid(pt_valid), .pt_last(pt_last), .pt_ready(pt_ready),
        .acc_ce(acc_ce), .acc_clr(acc_clr), .res_valid(res_valid), .res_ready(res_ready),
        .res_cnt(res_cnt), .err(err));
    inertia_acc_ctrl #(.ADD_LAT(0), .CNT_W(4), .TMO(8)) dut4 (
        .clk(clk), .rst(rst), .pt_valid(pt_valid), .pt_last(pt_last), .pt_ready(pt_ready4),
        .acc_ce(acc_ce4), .acc_clr(acc_clr4), .res_valid(res_valid4), .res_ready(res_ready),
        .res_cnt(res_cnt4), .err(err4));
`else
    inertia_acc_ctrl #(.ADD_LAT(3), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .pt_valid(pt_valid), .pt_last(pt_last), .pt_ready(pt_ready),
        .acc_ce(acc_ce), .acc_clr(acc_clr), .res_valid(res_valid), .res_ready(res_ready),
        .res_cnt(res_cnt), .err(err));
    inertia_acc_ctrl #(.ADD_LAT(0), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .pt_valid(pt_valid), .pt_last(pt_last), .pt_ready(pt_ready4),
        .acc_ce(acc_ce4), .acc_clr(acc_clr4), .res_valid(res_valid4), .res_ready(res_ready),
        .res_cnt(res_cnt4), .err(err4));
`endif

    task automatic cyc_drive(input logic v, input logic l, input logic rr);
        @(negedge clk);
        pt_valid  = v;
        pt_last   = l;
        res_ready = rr;
        #1;
    endtask

    task automatic push_exp(input int n);
        exp_t e;
        e.cnt  = n;
        e.cnt4 = (n > 15) ? 15 : n;
        sb.push_back(e);
    endtask

    task automatic send_cluster(input int n);
        for (int i = 1; i <= n; i++) cyc_drive(1'b1, (i == n), 1'b0);
        push_exp(n);
    endtask

    task automatic wait_hold(output int lat, output int lat4, output int ce_cnt);
        lat = -1;
        lat4 = -1;
        ce_cnt = 0;
        for (int k = 1; k <= 20; k++) begin
            cyc_drive(1'b0, 1'b0, 1'b0);
            if (res_valid4 && lat4 < 0) lat4 = k;
            if (acc_ce) ce_cnt++;
            if (res_valid) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        cyc_drive(1'b1, 1'b0, 1'b0);
        cyc_drive(1'b1, 1'b1, 1'b1);
        checks++;
        if ({pt_ready, acc_ce, acc_clr, res_valid, err} !== 5'b0 || res_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_outputs: got ctl=%b cnt=%0d, want ctl=00000 cnt=0",
                     {pt_ready, acc_ce, acc_clr, res_valid, err}, res_cnt);
        end
        checks++;
        if ({pt_ready4, acc_ce4, acc_clr4, res_valid4, err4} !== 5'b0 || res_cnt4 !== 4'd0) begin
            errors++;
            $display("FAIL reset_outputs4: got ctl=%b cnt=%0d, want ctl=00000 cnt=0",
                     {pt_ready4, acc_ce4, acc_clr4, res_valid4, err4}, res_cnt4);
        end
        @(negedge clk);
        rst = 1'b1;
        pt_valid = 1'b0;
        pt_last = 1'b0;
        res_ready = 1'b0;
        #1;
        checks++;
        if (pt_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: got %b, want 1", pt_ready);
        end
    endtask

    task automatic test_cluster5();
        int lat, lat4, ce, ce2;
        exp_t e;
        ce = 0;
        for (int i = 1; i <= 5; i++) begin
            cyc_drive(1'b1, (i == 5), 1'b0);
            checks++;
            if (pt_ready !== 1'b1 || acc_clr !== (i == 1)) begin
                errors++;
                $display("FAIL cl5_accept[%0d]: got ready=%b clr=%b, want ready=1 clr=%b",
                         i, pt_ready, acc_clr, (i == 1));
            end
            if (acc_ce) ce++;
        end
        push_exp(5);
        wait_hold(lat, lat4, ce2);
        ce += ce2;
        checks++;
        if (lat !== 4) begin
            errors++;
            $display("FAIL cl5_latency: got %0d, want 4", lat);
        end
        checks++;
        if (lat4 !== 1) begin
            errors++;
            $display("FAIL cl5_latency_lat0: got %0d, want 1", lat4);
        end
        checks++;
        if (ce !== 8) begin
            errors++;
            $display("FAIL cl5_ce_cycles: got %0d, want 8", ce);
        end
        e = sb.pop_front();
        checks++;
        if (res_cnt !== 16'(e.cnt) || res_cnt4 !== 4'(e.cnt4)) begin
            errors++;
            $display("FAIL cl5_cnt: got %0d/%0d, want %0d/%0d", res_cnt, res_cnt4, e.cnt, e.cnt4);
        end
        cyc_drive(1'b0, 1'b0, 1'b1);
        cyc_drive(1'b0, 1'b0, 1'b0);
        checks++;
        if (res_valid !== 1'b0 || pt_ready !== 1'b1) begin
            errors++;
            $display("FAIL cl5_release: got valid=%b ready=%b, want valid=0 ready=1", res_valid, pt_ready);
        end
    endtask

    task automatic test_single();
        int lat, lat4, ce;
        exp_t e;
        cyc_drive(1'b1, 1'b1, 1'b0);
        checks++;
        if ({acc_clr, acc_ce, pt_ready} !== 3'b111) begin
            errors++;
            $display("FAIL single_accept: got clr/ce/ready=%b, want 111", {acc_clr, acc_ce, pt_ready});
        end
        push_exp(1);
        wait_hold(lat, lat4, ce);
        checks++;
        if (lat !== 4 || ce !== 3 || lat4 !== 1) begin
            errors++;
            $display("FAIL single_drain: got lat=%0d drain=%0d lat0=%0d, want 4 3 1", lat, ce, lat4);
        end
        e = sb.pop_front();
        checks++;
        if (res_cnt !== 16'(e.cnt) || res_cnt4 !== 4'(e.cnt4)) begin
            errors++;
            $display("FAIL single_cnt: got %0d/%0d, want %0d/%0d", res_cnt, res_cnt4, e.cnt, e.cnt4);
        end
        cyc_drive(1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_hold();
        int lat, lat4, ce;
        send_cluster(3);
        wait_hold(lat, lat4, ce);
        for (int i = 0; i < 10; i++) begin
            cyc_drive(1'b1, 1'b0, 1'b0);
            checks++;
            if (res_valid !== 1'b1 || pt_ready !== 1'b0 || acc_ce !== 1'b0 || acc_clr !== 1'b0 ||
                res_cnt !== 16'(sb[0].cnt) || res_valid4 !== 1'b1) begin
                errors++;
                $display("FAIL hold[%0d]: got valid=%b ready=%b ce=%b clr=%b cnt=%0d v4=%b, want 1 0 0 0 %0d 1",
                         i, res_valid, pt_ready, acc_ce, acc_clr, res_cnt, res_valid4, sb[0].cnt);
            end
        end
    endtask

    task automatic test_back_to_back();
        int lat, lat4, ce;
        exp_t e;
        cyc_drive(1'b1, 1'b1, 1'b1);
        checks++;
        if (pt_ready !== 1'b0 || acc_ce !== 1'b0) begin
            errors++;
            $display("FAIL b2b_take_cycle: got ready=%b ce=%b, want 0 0", pt_ready, acc_ce);
        end
        e = sb.pop_front();
        checks++;
        if (res_cnt !== 16'(e.cnt) || res_cnt4 !== 4'(e.cnt4)) begin
            errors++;
            $display("FAIL b2b_first_cnt: got %0d/%0d, want %0d/%0d", res_cnt, res_cnt4, e.cnt, e.cnt4);
        end
        cyc_drive(1'b1, 1'b1, 1'b0);
        checks++;
        if (res_valid !== 1'b0 || pt_ready !== 1'b1 || acc_clr !== 1'b1) begin
            errors++;
            $display("FAIL b2b_restart: got valid=%b ready=%b clr=%b, want 0 1 1", res_valid, pt_ready, acc_clr);
        end
        push_exp(1);
        wait_hold(lat, lat4, ce);
        e = sb.pop_front();
        checks++;
        if (lat !== 4 || res_cnt !== 16'(e.cnt)) begin
            errors++;
            $display("FAIL b2b_second: got lat=%0d cnt=%0d, want 4 %0d", lat, res_cnt, e.cnt);
        end
        cyc_drive(1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_saturate();
        int lat, lat4, ce;
        exp_t e;
        send_cluster(20);
        wait_hold(lat, lat4, ce);
        e = sb.pop_front();
        checks++;
        if (res_cnt !== 16'(e.cnt) || res_cnt4 !== 4'(e.cnt4) || res_valid4 !== 1'b1) begin
            errors++;
            $display("FAIL saturate: got %0d/%0d v4=%b, want %0d/%0d 1", res_cnt, res_cnt4, res_valid4, e.cnt, e.cnt4);
        end
        cyc_drive(1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_reset_drain();
        cyc_drive(1'b1, 1'b0, 1'b0);
        cyc_drive(1'b1, 1'b1, 1'b0);
        cyc_drive(1'b0, 1'b0, 1'b0);
        checks++;
        if (acc_ce !== 1'b1 || res_valid !== 1'b0 || res_valid4 !== 1'b1) begin
            errors++;
            $display("FAIL rstd_in_drain: got ce=%b valid=%b v4=%b, want 1 0 1", acc_ce, res_valid, res_valid4);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if ({pt_ready, acc_ce, acc_clr, res_valid, err, pt_ready4, acc_ce4, res_valid4, err4} !== 9'b0 ||
            res_cnt !== 16'd0 || res_cnt4 !== 4'd0) begin
            errors++;
            $display("FAIL rstd_outputs: got ctl=%b cnt=%0d/%0d, want 0 0/0",
                     {pt_ready, acc_ce, acc_clr, res_valid, err, pt_ready4, acc_ce4, res_valid4, err4},
                     res_cnt, res_cnt4);
        end
        cyc_drive(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (res_valid !== 1'b0 || pt_ready !== 1'b1 || sb.size() != 0) begin
            errors++;
            $display("FAIL rstd_idle: got valid=%b ready=%b pending=%0d, want 0 1 0", res_valid, pt_ready, sb.size());
        end
        test_cluster5();
    endtask

`ifdef INERTIA_ACC_CTRL_TIMEOUT_EN
    task automatic test_timeout();
        int nerr, errk, nerr4;
        bit seen_valid;
        nerr = 0;
        nerr4 = 0;
        errk = -1;
        seen_valid = 1'b0;
        cyc_drive(1'b1, 1'b0, 1'b0);
        cyc_drive(1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 12; k++) begin
            cyc_drive(1'b0, 1'b0, 1'b0);
            if (res_valid) seen_valid = 1'b1;
            if (err4) nerr4++;
            if (err) begin
                nerr++;
                if (errk < 0) errk = k;
                checks++;
                if (acc_clr !== 1'b1) begin
                    errors++;
                    $display("FAIL tmo_clr: got %b, want 1", acc_clr);
                end
            end
        end
        checks++;
        if (nerr !== 1 || errk !== 8 || nerr4 !== 1 || seen_valid || pt_ready !== 1'b1) begin
            errors++;
            $display("FAIL tmo_abort: got pulses=%0d at=%0d pulses4=%0d valid_seen=%b ready=%b, want 1 8 1 0 1",
                     nerr, errk, nerr4, seen_valid, pt_ready);
        end
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_cluster5();
        test_single();
        test_hold();
        test_back_to_back();
        test_saturate();
        test_reset_drain();
`ifdef INERTIA_ACC_CTRL_TIMEOUT_EN
        test_timeout();
`endif
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
